store_rmw_unit: RTL and testbench
=================================

Name: store_rmw_unit

Overview:
- Store-side counterpart of the immediate/load extender: truncates register data to byte/halfword and inserts it into the correct lane of a 32-bit word.
- Sits between the CPU store path and a word-only data memory that has no byte enables.
- Byte and halfword stores use a read-modify-write sequence; word stores write directly.
- Request/ready handshake toward the core; done/err pulses report completion.

Parameters:
ADDR_WIDTH, 32, width of byte address (≥3)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  1  store request present
req_ready  output  1  unit idle, request accepted when req_valid & req_ready
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  source register value; only low 8/16/32 bits used
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
mem_addr  output  ADDR_WIDTH  word-aligned memory address
mem_rd_en  output  1  memory read strobe
mem_rdata  input  32  memory read data
mem_rd_valid  input  1  mem_rdata valid
mem_wr_en  output  1  memory write strobe
mem_wdata  output  32  merged word to write
done  output  1  one-cycle pulse, store completed
err  output  1  one-cycle pulse, request rejected (misaligned/illegal)

Behaviour:
- Moore FSM: IDLE, RD, WAIT, WR, DONE, ERR. All outputs are decoded from state and latched registers, with no combinational path from inputs.
- Reset (reset=0, async): state=IDLE, latched addr/data/size/merge word=0.
  - Outputs during and after reset: req_ready=1, mem_addr=0, mem_wdata=0, mem_rd_en=mem_wr_en=done=err=0.
- IDLE: req_ready=1. On acceptance, latch req_addr, req_wdata and req_size, then branch:
  - size=3, size=1 with addr[0]=1, or size=2 with addr[1:0]≠0 -> ERR.
  - size=2 -> WR, with merge word = req_wdata.
  - size=0/1 -> RD.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored; there is no queuing.
- mem_addr = {latched addr[ADDR_WIDTH-1:2], 2'b00}. It is held constant from the cycle after acceptance through DONE.
- RD: mem_rd_en=1 for exactly one cycle, then -> WAIT. Memory responds no earlier than the next cycle.
- WAIT: hold until mem_rd_valid=1 with no timeout. On the valid cycle, capture the merge word from mem_rdata and go to WR.
  - Merge is little-endian.
  - Byte: lane n = addr[1:0] replaced with req_wdata[7:0]; bits [8n+7:8n].
  - Half: bits [16*addr[1]+15 : 16*addr[1]] replaced with req_wdata[15:0].
  - All other bits are kept from mem_rdata.
- mem_rd_valid is ignored in every state except WAIT.
- WR: mem_wr_en=1 for exactly one cycle, with mem_wdata = merge word, then -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- ERR: err=1 for one cycle, then -> IDLE. No memory strobes are issued.
- Latency, with acceptance at edge 0:
  - Word store: WR in cycle 1, done in cycle 2, req_ready=1 in cycle 3.
  - Byte/half store with rd_valid k cycles after RD (k≥1): WR in cycle 2+k, done in cycle 3+k.
  - Illegal request: err in cycle 1, ready in cycle 2.
- Reset asserted mid-operation (any state) aborts the store. No mem_wr_en is issued for the aborted request, and a later mem_rd_valid from memory is ignored.
- mem_wdata is 0 outside WR; mem_rd_en and mem_wr_en are never asserted in the same cycle.

Test Plan:
1. sw addr=0x100, data=0xDEADBEEF -> no mem_rd_en; mem_wr_en one cycle in cycle 1 with mem_addr=0x100, mem_wdata=0xDEADBEEF; done in cycle 2; req_ready high again in cycle 3.
2. sb addr=0x102, data=0xFFFFFFAB; memory returns 0x11223344 one cycle after RD -> mem_addr=0x100, mem_wr_en with mem_wdata=0x11AB3344, then done.
3. sh addr=0x106, data=0x0000CAFE; memory returns 0x55667788 -> mem_addr=0x104, mem_wdata=0xCAFE7788. Also sh addr=0x104 -> mem_wdata=0x5566CAFE.
4. Reject cases -> each gives err pulse in cycle 1, no strobes, done=0, ready in cycle 2:
   - sh addr=0x101
   - sw addr=0x102
   - size=3 addr=0x100
5. sb addr=0x203 with mem_rd_valid delayed 5 cycles, req_valid held high throughout, plus a spurious mem_rd_valid pulse in IDLE:
   - req_ready stays 0 until done.
   - Merged byte lands in bits [31:24].
   - Spurious pulse causes no strobe.
   - Next request is accepted the cycle after DONE.
6. reset driven low during WAIT, then mem_rd_valid arrives after release -> all outputs at reset values immediately; no mem_wr_en; a following sw addr=0x0, data=0x12345678 completes normally.

Source files
------------

// File: rtl/store_rmw_unit.sv
// Store unit for a word-only memory: word stores write directly; byte/half stores
// read the word, merge the new lane little-endian, then write it back.
module store_rmw_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rd_valid,
  output logic                  mem_wr_en,
  output logic [31:0]           mem_wdata,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned HALF_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE,
    S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [HALF_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              size_q, size_d;
  logic [DATA_WIDTH-1:0]   merge_q, merge_d;
  logic [DATA_WIDTH-1:0]   merged_c;
  logic                    illegal_c;

  // Only the low halfword of the source is ever needed for a sub-word merge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      merge_q <= merge_d;
    end
  end

  // Little-endian lane insertion into the word returned by memory
  always_comb begin
    merged_c = mem_rdata;
    if (size_q == 2'd0) begin
      merged_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_c[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  assign illegal_c = (req_size == 2'd3)
                   | ((req_size == 2'd1) & req_addr[0])
                   | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    merge_d = merge_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata[HALF_WIDTH-1:0];
          size_d  = req_size;
          if (illegal_c) begin
            state_d = S_ERR;
          end else if (req_size == 2'd2) begin
            merge_d = req_wdata;
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rd_valid) begin
          merge_d = merged_c;
          state_d = S_WR;
        end
      end
      S_WR:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from flops only
  assign req_ready = (state_q == S_IDLE);
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_rd_en = (state_q == S_RD);
  assign mem_wr_en = (state_q == S_WR);
  assign mem_wdata = (state_q == S_WR) ? merge_q : '0;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit with hand-computed merge results and cycle timing.
module tb_store_rmw_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_rd_valid;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  store_rmw_unit #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rdata    (mem_rdata),
    .mem_rd_valid (mem_rd_valid),
    .mem_wr_en    (mem_wr_en),
    .mem_wdata    (mem_wdata),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    check({tag, ".rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, ".wr_en"}, 32'(mem_wr_en), 32'd0);
    check({tag, ".wdata"}, mem_wdata, 32'h0);
    check({tag, ".done"},  32'(done), 32'd0);
    check({tag, ".err"},   32'(err), 32'd0);
  endtask

  task automatic put_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_size  = s;
  endtask

  // Sub-word store; rd_valid arrives k cycles after the RD cycle
  task automatic rmw_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input logic [31:0] rdata, input int k,
                           input bit hold, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata);
    put_req(a, d, s);
    check({tag, ".ready0"}, 32'(req_ready), 32'd1);
    tick();
    if (!hold) req_valid = 1'b0;
    check({tag, ".rd_en"},  32'(mem_rd_en), 32'd1);
    check({tag, ".addr_rd"}, mem_addr, exp_addr);
    check({tag, ".ready_rd"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < k; i++) begin
      tick();
      check({tag, ".wait_wr"}, 32'(mem_wr_en), 32'd0);
      check({tag, ".wait_rdy"}, 32'(req_ready), 32'd0);
      check({tag, ".wait_rd"}, 32'(mem_rd_en), 32'd0);
    end
    mem_rd_valid = 1'b1;
    mem_rdata    = rdata;
    tick();
    mem_rd_valid = 1'b0;
    mem_rdata    = 32'h0;
    check({tag, ".wr_en"},  32'(mem_wr_en), 32'd1);
    check({tag, ".rd_en_wr"}, 32'(mem_rd_en), 32'd0);
    check({tag, ".wdata"},  mem_wdata, exp_wdata);
    check({tag, ".addr_wr"}, mem_addr, exp_addr);
    check({tag, ".ready_wr"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, ".done"},   32'(done), 32'd1);
    check({tag, ".wr_off"}, 32'(mem_wr_en), 32'd0);
    check({tag, ".ready_dn"}, 32'(req_ready), 32'd0);
    check({tag, ".addr_dn"}, mem_addr, exp_addr);
    if (!hold) begin
      tick();
      check({tag, ".ready_end"}, 32'(req_ready), 32'd1);
      check({tag, ".done_off"}, 32'(done), 32'd0);
    end
  endtask

  task automatic word_store(input string tag, input logic [31:0] a, input logic [31:0] d);
    put_req(a, d, 2'd2);
    tick();
    req_valid = 1'b0;
    check({tag, ".wr_en"}, 32'(mem_wr_en), 32'd1);
    check({tag, ".rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, ".addr"},  mem_addr, a);
    check({tag, ".wdata"}, mem_wdata, d);
    check({tag, ".ready1"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, ".done"},  32'(done), 32'd1);
    check({tag, ".wr_off"}, 32'(mem_wr_en), 32'd0);
    check({tag, ".ready2"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, ".ready3"}, 32'(req_ready), 32'd1);
    check({tag, ".done3"}, 32'(done), 32'd0);
  endtask

  task automatic reject(input string tag, input logic [31:0] a, input logic [1:0] s);
    put_req(a, 32'hA5A5A5A5, s);
    tick();
    req_valid = 1'b0;
    check({tag, ".err"},   32'(err), 32'd1);
    check({tag, ".rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, ".wr_en"}, 32'(mem_wr_en), 32'd0);
    check({tag, ".done"},  32'(done), 32'd0);
    check({tag, ".ready1"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, ".err_off"}, 32'(err), 32'd0);
    check({tag, ".ready2"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_size     = 2'd0;
    mem_rdata    = 32'h0;
    mem_rd_valid = 1'b0;
    #12;
    check_idle_outs("rst");
    check("rst.addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_idle_outs("post_rst");

    word_store("sw100", 32'h100, 32'hDEADBEEF);
    rmw_store("sb102", 32'h102, 32'hFFFFFFAB, 2'd0, 32'h11223344, 1, 1'b0,
              32'h100, 32'h11AB3344);
    rmw_store("sh106", 32'h106, 32'h0000CAFE, 2'd1, 32'h55667788, 1, 1'b0,
              32'h104, 32'hCAFE7788);
    rmw_store("sh104", 32'h104, 32'h0000CAFE, 2'd1, 32'h55667788, 1, 1'b0,
              32'h104, 32'h5566CAFE);
    rmw_store("sb100", 32'h100, 32'h00000099, 2'd0, 32'hFFFFFFFF, 2, 1'b0,
              32'h100, 32'hFFFFFF99);

    reject("sh101", 32'h101, 2'd1);
    reject("sw102", 32'h102, 2'd2);
    reject("sz3",   32'h100, 2'd3);

    // Spurious read-valid while idle must not start anything
    mem_rd_valid = 1'b1;
    mem_rdata    = 32'hFFFFFFFF;
    tick();
    mem_rd_valid = 1'b0;
    check_idle_outs("spur1");
    tick();
    check_idle_outs("spur2");

    rmw_store("sb203", 32'h203, 32'h0000005A, 2'd0, 32'h11223344, 5, 1'b1,
              32'h200, 32'h5A223344);
    // Held request: idle cycle after DONE accepts the new word store
    put_req(32'h300, 32'hCAFEF00D, 2'd2);
    tick();
    check("held.ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("held.wr_en", 32'(mem_wr_en), 32'd1);
    check("held.addr",  mem_addr, 32'h300);
    check("held.wdata", mem_wdata, 32'hCAFEF00D);
    tick();
    check("held.done", 32'(done), 32'd1);
    tick();

    // Abort during WAIT, then late read data must be ignored
    put_req(32'h0, 32'h000000EE, 2'd0);
    tick();
    req_valid = 1'b0;
    check("abort.rd_en", 32'(mem_rd_en), 32'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_idle_outs("abort");
    check("abort.addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    mem_rd_valid = 1'b1;
    mem_rdata    = 32'h87654321;
    tick();
    mem_rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle_outs("abort_late");
      tick();
    end
    word_store("sw0", 32'h0, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Read and write strobes must never overlap
  always @(negedge clk) begin
    if (reset && mem_rd_en && mem_wr_en) check("rd_wr_overlap", 32'd1, 32'd0);
  end

endmodule
